// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER data-memory port arbiter.
package otter_arb_pkg;

    typedef enum logic {ST_IDLE, ST_RESP} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} arb_owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // One memory-port request: requester fields and the hold register share this layout.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
    } mem_req_t;

endpackage

// File: rtl/otter_starve_ctr.sv
// Saturating wait counter that lets the debug requester break CPU priority.
module otter_starve_ctr #(
    parameter logic [7:0] LIMIT = 8'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [7:0] cnt;

    // Count waiting cycles, clear on grant or withdrawn request, hold at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Two-requester arbiter for the OTTER memory data port. CPU has priority;
// reads take a grant cycle plus a data cycle with the port fields frozen.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | arbitration open; winner drives the memory port directly
// ST_RESP | read data cycle; address/size/sign replayed from hold
module otter_dmem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_din,
    input  logic [1:0]  dbg_size,
    input  logic        dbg_sign,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    output logic        mem_rden2,
    output logic        mem_we2,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout2
);

    arb_state_t state, state_nxt;
    arb_owner_t owner, owner_nxt;
    mem_req_t   hold, hold_nxt;
    mem_req_t   cpu_fields, dbg_fields, win;
    logic       cpu_win, dbg_win;
    logic       dbg_at_limit;
    logic       starve_inc, starve_clr;

    assign cpu_fields = {cpu_we, cpu_addr, cpu_din, cpu_size, cpu_sign};
    assign dbg_fields = {dbg_we, dbg_addr, dbg_din, dbg_size, dbg_sign};

    // RESP grants nothing, so DBG keeps accumulating wait cycles there too.
    assign starve_inc = dbg_req && !dbg_gnt;
    assign starve_clr = dbg_gnt || !dbg_req;

    otter_starve_ctr #(
        .LIMIT (STARVE_LIMIT[7:0])
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (dbg_at_limit)
    );

    // State, owner and held request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= OWN_CPU;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            hold  <= hold_nxt;
        end
    end

    // Arbitration, memory port drive, read response routing and next state.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        hold_nxt   = hold;
        win        = '0;
        cpu_win    = 1'b0;
        dbg_win    = 1'b0;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rdata  = '0;
        mem_rden2  = 1'b0;
        mem_we2    = 1'b0;
        mem_addr2  = '0;
        mem_din2   = '0;
        mem_size   = '0;
        mem_sign   = 1'b0;

        case (state)
            ST_IDLE: begin
                dbg_win = dbg_req && (!cpu_req || dbg_at_limit);
                cpu_win = cpu_req && !dbg_win;
                if (dbg_win) begin
                    win = dbg_fields;
                end else if (cpu_win) begin
                    win = cpu_fields;
                end

                if (cpu_win || dbg_win) begin
                    cpu_gnt   = cpu_win;
                    dbg_gnt   = dbg_win;
                    mem_we2   = win.we;
                    mem_rden2 = !win.we;
                    mem_addr2 = win.addr;
                    mem_din2  = win.din;
                    mem_size  = win.size;
                    mem_sign  = win.sign;
                    hold_nxt  = win;
                    owner_nxt = dbg_win ? OWN_DBG : OWN_CPU;
                    if (!win.we) begin
                        state_nxt = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // The memory sizes its output from these, so they must stay put.
                mem_addr2 = hold.addr;
                mem_size  = hold.size;
                mem_sign  = hold.sign;
                // RESP is only entered from a read, so din is 0 and the response is valid.
                mem_din2  = hold.we ? hold.din : '0;
                if (!hold.we) begin
                    if (owner == OWN_DBG) begin
                        dbg_rvalid = 1'b1;
                        dbg_rdata  = mem_dout2;
                    end else begin
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_dout2;
                    end
                end
                state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Self-checking bench for otter_dmem_arbiter with a behavioural sized memory.
module tb_otter_dmem_arbiter;
    import otter_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [31:0] cpu_addr, cpu_din;
    logic [1:0]  cpu_size;
    logic        dbg_req, dbg_we, dbg_sign;
    logic [31:0] dbg_addr, dbg_din;
    logic [1:0]  dbg_size;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_rden2, mem_we2, mem_sign;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_size;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        dbg;
        logic [31:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct packed {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [15];

    otter_dmem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_size   (cpu_size),
        .cpu_sign   (cpu_sign),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_din    (dbg_din),
        .dbg_size   (dbg_size),
        .dbg_sign   (dbg_sign),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_rden2  (mem_rden2),
        .mem_we2    (mem_we2),
        .mem_addr2  (mem_addr2),
        .mem_din2   (mem_din2),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .mem_dout2  (mem_dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous word read, combinational sizing from the live port fields.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word;

    function automatic logic [31:0] size_rd(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] m, d;
        case (sz)
            2'd0: begin m = 32'h0000_00FF << {off, 3'b000};  d = din << {off, 3'b000}; end
            2'd1: begin m = 32'h0000_FFFF << {off[1], 4'h0}; d = din << {off[1], 4'h0}; end
            default: begin m = 32'hFFFF_FFFF; d = din; end
        endcase
        return (old & ~m) | (d & m);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[10'h040] <= 32'hDEAD_BEEF;
            mem[10'h080] <= 32'h8000_0000;
        end else begin
            if (mem_rden2)
                rd_word <= (mem_addr2 >= 32'h0001_0000) ? 32'h1234_5678 : mem[mem_addr2[11:2]];
            if (mem_we2)
                mem[mem_addr2[11:2]] <= merge(mem[mem_addr2[11:2]], mem_din2, mem_addr2[1:0], mem_size);
        end
    end

    assign mem_dout2 = size_rd(rd_word, mem_addr2[1:0], mem_size, mem_sign);

    logic [136:0] all_out;
    assign all_out = {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata,
                      mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign};

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon_port(input logic rv, input logic [31:0] rd, input logic is_dbg);
        sb_t e;
        if (rv) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_rvalid: got rvalid on %s with data %h, expected none",
                         is_dbg ? "dbg" : "cpu", rd);
            end else begin
                e = sbq.pop_front();
                chk("sb_rdata", {is_dbg, rd}, {e.dbg, e.data});
            end
        end else begin
            chk("rdata_zero_when_idle", rd, 0);
        end
    endtask

    // Scoreboard consumer: every read response is matched against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(cpu_rvalid, cpu_rdata, 1'b0);
            mon_port(dbg_rvalid, dbg_rdata, 1'b1);
        end
    end

    task automatic clear_req();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; cpu_size = 0; cpu_sign = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_din = 0; dbg_size = 0; dbg_sign = 0;
    endtask

    task automatic set_req(input logic is_dbg, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [1:0] size, input logic sign);
        if (is_dbg) begin
            dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_din = din; dbg_size = size; dbg_sign = sign;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_size = size; cpu_sign = sign;
        end
    endtask

    function automatic vec_t mk(input logic is_dbg, input logic we, input logic [31:0] addr,
                                input logic [31:0] din, input logic [1:0] size, input logic sign,
                                input logic [31:0] exp);
        return {is_dbg, we, addr, din, size, sign, exp};
    endfunction

    task automatic do_txn(input vec_t v);
        int  n;
        logic g;
        @(posedge clk); #1;
        set_req(v.dbg, v.we, v.addr, v.din, v.size, v.sign);
        @(negedge clk);
        n = 0;
        g = v.dbg ? dbg_gnt : cpu_gnt;
        while (!g && n < 8) begin
            @(negedge clk);
            g = v.dbg ? dbg_gnt : cpu_gnt;
            n++;
        end
        chk("txn_gnt", {cpu_gnt, dbg_gnt}, v.dbg ? 2'b01 : 2'b10);
        chk("txn_port", {mem_we2, mem_rden2, mem_addr2, mem_din2, mem_size, mem_sign},
            {v.we, !v.we, v.addr, v.din, v.size, v.sign});
        if (g && !v.we) sbq.push_back({v.dbg, v.exp});
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        if (v.we)
            chk("txn_idle_after_write", all_out, 0);
        else
            chk("txn_resp_port", {cpu_gnt, dbg_gnt, mem_we2, mem_rden2, mem_addr2, mem_din2, mem_size, mem_sign},
                {4'b0000, v.addr, 32'h0, v.size, v.sign});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 0, 32'h0000_0000, 0, SZ_WORD, 0, 32'h0000_0001);
        vecs[1]  = mk(0, 0, 32'h0000_0004, 0, SZ_WORD, 0, 32'h0000_0002);
        vecs[2]  = mk(1, 0, 32'h0000_0008, 0, SZ_WORD, 0, 32'h0000_0003);
        vecs[3]  = mk(0, 0, 32'h0000_0100, 0, SZ_WORD, 0, 32'hDEAD_BEEF);
        vecs[4]  = mk(0, 1, 32'h0000_0010, 32'hA5A5_1234, SZ_WORD, 0, 0);
        vecs[5]  = mk(0, 0, 32'h0000_0010, 0, SZ_WORD, 0, 32'hA5A5_1234);
        vecs[6]  = mk(0, 0, 32'h0000_0012, 0, SZ_HALF, 1, 32'h0000_A5A5);
        vecs[7]  = mk(0, 0, 32'h0000_0012, 0, SZ_HALF, 0, 32'hFFFF_A5A5);
        vecs[8]  = mk(0, 0, 32'h0000_0010, 0, SZ_BYTE, 0, 32'h0000_0034);
        vecs[9]  = mk(1, 1, 32'h0000_0011, 32'hFFFF_FF99, SZ_BYTE, 0, 0);
        vecs[10] = mk(1, 0, 32'h0000_0010, 0, SZ_WORD, 0, 32'hA5A5_9934);
        vecs[11] = mk(1, 1, 32'h0000_0016, 32'h0000_BEEF, SZ_HALF, 0, 0);
        vecs[12] = mk(0, 0, 32'h0000_0014, 0, SZ_WORD, 0, 32'hBEEF_0000);
        vecs[13] = mk(1, 0, 32'h0000_0203, 0, SZ_BYTE, 0, 32'hFFFF_FF80);
        vecs[14] = mk(0, 0, 32'h0001_0004, 0, SZ_WORD, 0, 32'h1234_5678);

        // Reset, then idle with no requests.
        rst_n = 0;
        clear_req();
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", all_out, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_outputs", all_out, 0);
        end

        // Back-to-back CPU writes: one grant per cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1, 32'(i * 4), 32'(i + 1), SZ_WORD, 0);
            @(negedge clk);
            chk("b2b_write_gnt", {cpu_gnt, mem_we2, mem_addr2, mem_din2}, {2'b11, 32'(i * 4), 32'(i + 1)});
            @(posedge clk); #1;
        end
        clear_req();

        // Table of single transactions.
        for (int i = 0; i < 15; i++) do_txn(vecs[i]);

        // Starvation: both request writes every cycle; DBG wins on its 9th waiting cycle.
        @(posedge clk); #1;
        set_req(1, 1, 32'h0000_0044, 32'h0000_0077, SZ_WORD, 0);
        for (int k = 0; k < 10; k++) begin
            set_req(0, 1, 32'h0000_0040, 32'(k), SZ_WORD, 0);
            @(negedge clk);
            chk("starve_gnt", {cpu_gnt, dbg_gnt}, (k == 8) ? 2'b01 : 2'b10);
            if (k == 8) chk("starve_dbg_port", {mem_we2, mem_addr2, mem_din2}, {1'b1, 32'h44, 32'h77});
            @(posedge clk); #1;
        end
        clear_req();

        // DBG unsigned byte read; CPU request raised in the RESP cycle is granted next cycle.
        @(posedge clk); #1;
        set_req(1, 0, 32'h0000_0203, 0, SZ_BYTE, 1);
        @(negedge clk);
        chk("d_dbg_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        if (dbg_gnt) sbq.push_back({1'b1, 32'h0000_0080});
        @(posedge clk); #1;
        clear_req();
        set_req(0, 0, 32'h0000_0100, 0, SZ_WORD, 0);
        @(negedge clk);
        chk("d_no_gnt_in_resp", {cpu_gnt, dbg_gnt, dbg_rvalid}, 3'b001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d_cpu_gnt_next", {cpu_gnt, dbg_gnt, mem_rden2}, 3'b101);
        if (cpu_gnt) sbq.push_back({1'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);

        // Reset asserted during RESP aborts the read.
        @(posedge clk); #1;
        set_req(0, 0, 32'h0000_0100, 0, SZ_WORD, 0);
        @(negedge clk);
        chk("e_cpu_gnt", cpu_gnt, 1);
        @(posedge clk); #1;
        clear_req();
        chk("e_rvalid_before_rst", cpu_rvalid, 1);
        #1;
        rst_n = 0;
        #1;
        chk("e_abort_outputs", all_out, 0);
        @(negedge clk);
        chk("e_reset_hold", all_out, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("e_idle_after_release", all_out, 0);
        do_txn(mk(0, 0, 32'h0000_0100, 0, SZ_WORD, 0, 32'hDEAD_BEEF));

        @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
